// File: rtl/traffic_pkg.sv
// Shared timing constants for the traffic-light controller, plus a counter-width helper
// so every block sizes its tick counters the same way.
package traffic_pkg;

    localparam int unsigned CLK_FREQ_HZ_DEFAULT = 50_000_000;
    localparam int unsigned SIM_DIV_DEFAULT     = 50;

    // Width for a div_count_t-style counter covering 0..value-1; never narrower than 1 bit.
    function automatic int unsigned clog2_safe(input int unsigned value);
        return (value < 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/divider.sv
// Clock-enable generator: divides clk by DIV and emits a registered single-cycle strobe.
// Define DIVIDER_FAST_SIM_EN to use the short SIM_DIV ratio instead of CLK_FREQ_HZ/ENABLE_FREQ_HZ.
module divider
    import traffic_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = CLK_FREQ_HZ_DEFAULT,
    parameter int unsigned ENABLE_FREQ_HZ = 1,
    parameter int unsigned SIM_DIV        = SIM_DIV_DEFAULT,
`ifdef DIVIDER_FAST_SIM_EN
    localparam int unsigned DIV           = SIM_DIV,
`else
    localparam int unsigned DIV           = CLK_FREQ_HZ / ENABLE_FREQ_HZ,
`endif
    localparam int unsigned CW            = clog2_safe(DIV)
) (
    input  logic          clk,
    input  logic          global_reset_n,
    input  logic          divider_reset,
    output logic          enable_1Hz,
    output logic [CW-1:0] div_count
);

    if (DIV < 2) begin : g_bad_div
        $error("divider: DIV must be at least 2");
    end
    if ((CLK_FREQ_HZ % ENABLE_FREQ_HZ) != 0) begin : g_bad_ratio
        $error("divider: CLK_FREQ_HZ must be an integer multiple of ENABLE_FREQ_HZ");
    end
    if (SIM_DIV < 2) begin : g_bad_sim_div
        $error("divider: SIM_DIV must be at least 2");
    end

    localparam logic [CW-1:0] TERMINAL = CW'(DIV - 1);

    logic [CW-1:0] r_div_count;
    logic          r_enable;
    logic          w_at_terminal;

    assign w_at_terminal = (r_div_count == TERMINAL);

    // Wrap is explicit at TERMINAL so non-power-of-two ratios never overflow naturally.
    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_div_count <= '0;
            r_enable    <= 1'b0;
        end else if (divider_reset) begin
            r_div_count <= '0;
            r_enable    <= 1'b0;
        end else if (w_at_terminal) begin
            r_div_count <= '0;
            r_enable    <= 1'b1;
        end else begin
            r_div_count <= r_div_count + 1'b1;
            r_enable    <= 1'b0;
        end
    end

    assign enable_1Hz = r_enable;
    assign div_count  = r_div_count;

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for divider: a DIV=50 instance and a DIV=1000 full-rate instance.
module tb_divider;

    logic       clk;
    logic       global_reset_n;
    logic       divider_reset;
    logic       full_reset;
    logic       en;
    logic [5:0] dcnt;
    logic       fen;
    logic [9:0] fcnt;

    int n_checks = 0;
    int n_errors = 0;

    divider #(
        .CLK_FREQ_HZ   (50),
        .ENABLE_FREQ_HZ(1),
        .SIM_DIV       (50)
    ) u_dut (
        .clk           (clk),
        .global_reset_n(global_reset_n),
        .divider_reset (divider_reset),
        .enable_1Hz    (en),
        .div_count     (dcnt)
    );

    divider #(
        .CLK_FREQ_HZ   (1000),
        .ENABLE_FREQ_HZ(1),
        .SIM_DIV       (1000)
    ) u_full (
        .clk           (clk),
        .global_reset_n(global_reset_n),
        .divider_reset (full_reset),
        .enable_1Hz    (fen),
        .div_count     (fcnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One rising edge, then sample on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int pulses;
        int last;

        global_reset_n = 1'b0;
        divider_reset  = 1'b0;
        full_reset     = 1'b0;

        // Reset held for 100 ns
        for (int i = 0; i < 5; i++) begin
            #19;
            check("rst_en", en, 0);
            check("rst_cnt", dcnt, 0);
            check("rst_fcnt", fcnt, 0);
            #1;
        end

        @(negedge clk);
        global_reset_n = 1'b1;

        // Period: pulses after edges 50, 100, 150 with 49 low cycles between
        pulses = 0;
        last   = 0;
        for (int k = 1; k <= 150; k++) begin
            step();
            check("period_cnt", dcnt, k % 50);
            check("period_en", en, (k % 50 == 0) ? 1 : 0);
            if (en) begin
                pulses++;
                if (last > 0) check("period_gap", k - last - 1, 49);
                last = k;
            end
        end
        check("period_pulses", pulses, 3);

        // Restart mid-period at count 30
        for (int k = 1; k <= 30; k++) step();
        check("restart_pre_cnt", dcnt, 30);
        divider_reset = 1'b1;
        step();
        check("restart_cnt", dcnt, 0);
        check("restart_en", en, 0);
        divider_reset = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            step();
            check("restart_run_cnt", dcnt, k % 50);
            check("restart_run_en", en, (k == 50) ? 1 : 0);
        end

        // divider_reset on the terminal-count edge wins, and holding it freezes the block
        for (int k = 1; k <= 49; k++) step();
        check("simul_pre_cnt", dcnt, 49);
        divider_reset = 1'b1;
        step();
        check("simul_en", en, 0);
        check("simul_cnt", dcnt, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("hold_en", en, 0);
            check("hold_cnt", dcnt, 0);
        end
        divider_reset = 1'b0;

        // Run up to a pulse, then assert async reset between edges
        for (int k = 1; k <= 50; k++) step();
        check("async_pre_en", en, 1);
        #3;
        global_reset_n = 1'b0;
        #1;
        check("async_en", en, 0);
        check("async_cnt", dcnt, 0);
        check("async_fcnt", fcnt, 0);
        step();
        check("async_hold_en", en, 0);
        check("async_hold_cnt", dcnt, 0);
        global_reset_n = 1'b1;

        // Full-rate instance: 10-bit counter, pulse every 1000 cycles
        check("full_width", $bits(u_full.div_count), 10);
        pulses = 0;
        for (int k = 1; k <= 2000; k++) begin
            step();
            if (fen) pulses++;
            if (k == 999) begin
                check("full_cnt_999", fcnt, 999);
                check("full_en_999", fen, 0);
            end
            if (k == 1000 || k == 2000) begin
                check("full_en_pulse", fen, 1);
                check("full_cnt_wrap", fcnt, 0);
            end
        end
        check("full_pulses", pulses, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
